bcd_display_scan: RTL

Multiplexed 8-digit seven-segment driver that sits directly downstream of the binary-to-BCD converter. It takes the converter's 32-bit packed BCD result (8 nibbles) on a one-cycle load strobe. It double-buffers the value so updates land only on frame boundaries, and time-multiplexes the digits onto shared active-low anode/segment lines, with optional leading-zero blanking and a per-digit decimal point.

---
 rtl/bcd_display_scan.sv | 109 ++++++++++
 1 files changed

// File: rtl/bcd_display_scan.sv
// Eight-digit multiplexed seven-segment driver for packed BCD, with a frame-synchronous
// double buffer, optional leading-zero blanking and live per-digit decimal points.
module bcd_display_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int PCNT_W = $clog2(REFRESH_DIV);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(REFRESH_DIV - 1);

  logic [PCNT_W-1:0] pcnt;
  logic [2:0]        idx;
  logic [31:0]       shadow;
  logic [31:0]       disp;
  logic              pending;
  logic              wrap_p1;
  logic              tick;
  logic              wrap;
  logic [3:0]        nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every more-significant digit are zero;
  // digit 0 always stays visible so a zero value still shows "0".
  function automatic logic lz_blank(input logic [31:0] val, input logic [2:0] k,
                                    input logic en);
    logic nz;
    nz = 1'b0;
    for (int j = 0; j < 8; j++)
      if (3'(j) >= k && val[4*j +: 4] != 4'd0) nz = 1'b1;
    return en && (k != 3'd0) && !nz;
  endfunction

  assign tick = (pcnt == PCNT_MAX);
  assign wrap = tick && (idx == 3'd7);
  assign nib  = disp[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) idx <= idx + 3'd1;
    end
  end

  // A load landing on the frame boundary bypasses the shadow so it is not delayed a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      if (load) shadow <= bcd_in;
      if (wrap) begin
        pending <= 1'b0;
        if (load)         disp <= bcd_in;
        else if (pending) disp <= shadow;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Output stage: registered from idx/disp; frame_done lines up with digit 0 of the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      wrap_p1    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      an         <= ~(8'b1 << idx);
      seg        <= lz_blank(disp, idx, blank_lz) ? 7'h7F : seg_decode(nib);
      dp         <= ~dp_mask[idx];
      wrap_p1    <= wrap;
      frame_done <= wrap_p1;
    end
  end

endmodule
